// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix scan controller.
//   ROWS_DEF / COLS_DEF : default matrix geometry
//   idx_w()             : row/column index width for a given dimension
//   scan_state_e        : row scan FSM encoding (blanking gap, row drive)
package led_matrix_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// Pixel write / frame control port between game logic and the scan controller.
//   wr_valid, wr_row, wr_col, wr_data : pixel write request (game logic -> ctrl)
//   wr_ready                          : write accepted when wr_valid & wr_ready
//   clear_req                         : one-cycle pulse, clears back buffer
//   commit                            : one-cycle pulse, request back->front swap
//   commit_pending                    : swap requested but not yet applied
interface led_matrix_scan_ctrl_if #(
  parameter int ROWS    = led_matrix_pkg::ROWS_DEF,
  parameter int COLUMNS = led_matrix_pkg::COLS_DEF
);
  import led_matrix_pkg::*;

  logic                       wr_valid;
  logic                       wr_ready;
  logic [idx_w(ROWS)-1:0]     wr_row;
  logic [idx_w(COLUMNS)-1:0]  wr_col;
  logic                       wr_data;
  logic                       clear_req;
  logic                       commit;
  logic                       commit_pending;

  modport master (
    output wr_valid, wr_row, wr_col, wr_data, clear_req, commit,
    input  wr_ready, commit_pending
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_data, clear_req, commit,
    output wr_ready, commit_pending
  );

endinterface

// File: rtl/led_matrix_scan_ctrl_scan_timer.sv
// Loadable down-counter shared by the blanking and dwell intervals.
//   clk_in, rst_n : clock, asynchronous active-low reset
//   clr           : force count to zero (scan disabled)
//   load/load_val : start an interval of load_val+1 cycles
//   done          : terminal count (count == 0), last cycle of the interval
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-multiplexing scan controller for an LED matrix with a double-buffered
// frame. Game logic writes pixels into the back buffer; a commit copies the
// back buffer into the displayed front buffer at the next frame boundary, so
// a frame is never shown half-updated. Each row is preceded by an all-off
// blanking gap to suppress ghosting.
//   clk_in, rst_n : clock, asynchronous active-low reset (clears both buffers)
//   scan_en       : scanning enable; low blanks outputs and restarts at row 0
//   wr            : pixel write / clear / commit port (slave side)
//   row_out       : one-hot row drive (registered)
//   col_out       : column data of the driven row (registered)
//   frame_start   : one-cycle pulse on the first blanking cycle of row 0
module led_matrix_scan_ctrl #(
  parameter int ROWS    = led_matrix_pkg::ROWS_DEF,
  parameter int COLUMNS = led_matrix_pkg::COLS_DEF,
  parameter int DWELL   = 1000,
  parameter int BLANK   = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  scan_en,
  led_matrix_scan_ctrl_if.slave wr,
  output logic [ROWS-1:0]       row_out,
  output logic [COLUMNS-1:0]    col_out,
  output logic                  frame_start
);
  import led_matrix_pkg::*;

  localparam int RW   = idx_w(ROWS);
  localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  scan_state_e               state_q, state_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      run_q, run_d;
  logic                      tmr_clr, tmr_load, tmr_done;
  logic [CW-1:0]             tmr_val;
  logic                      fs_d;
  logic                      wrap;
  logic                      swap;
  logic                      wr_fire;
  logic                      pend_q;
  logic [ROWS*COLUMNS-1:0]   back_q, front_q;
  logic [ROWS-1:0]           row_sel;
  logic [COLUMNS-1:0]        col_sel;

  scan_timer #(.W(CW)) u_timer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // run_q distinguishes "held idle by scan_en" from "scanning": the first
  // enabled cycle starts a full blanking interval for row 0 with frame_start.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    run_d    = run_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = BLANK_LD;
    fs_d     = 1'b0;
    wrap     = 1'b0;
    if (!scan_en) begin
      state_d = ST_BLANK;
      row_d   = '0;
      run_d   = 1'b0;
      tmr_clr = 1'b1;
    end else if (!run_q) begin
      state_d  = ST_BLANK;
      row_d    = '0;
      run_d    = 1'b1;
      tmr_load = 1'b1;
      tmr_val  = BLANK_LD;
      fs_d     = 1'b1;
    end else if (tmr_done) begin
      tmr_load = 1'b1;
      if (state_q == ST_BLANK) begin
        state_d = ST_DRIVE;
        tmr_val = DWELL_LD;
      end else begin
        state_d = ST_BLANK;
        tmr_val = BLANK_LD;
        if (row_q == LAST_ROW) begin
          row_d = '0;
          wrap  = 1'b1;
          fs_d  = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      row_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      run_q   <= run_d;
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // state_q. The front buffer never changes on an edge entering DRIVE, so the
  // current front contents are the ones displayed for the whole dwell.
  always_comb begin
    row_sel = ROWS'(1) << row_d;
    col_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_d == RW'(r)) col_sel = front_q[r*COLUMNS +: COLUMNS];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      row_out     <= '0;
      col_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      row_out     <= (state_d == ST_DRIVE) ? row_sel : '0;
      col_out     <= (state_d == ST_DRIVE) ? col_sel : '0;
      frame_start <= fs_d;
    end
  end

  assign wr.wr_ready       = ~wr.clear_req;
  assign wr.commit_pending = pend_q;
  assign wr_fire           = wr.wr_valid & wr.wr_ready;
  assign swap              = wrap & pend_q;

  // The swap reads back_q as registered, so a write or clear in the boundary
  // cycle only reaches the back buffer. A commit in that cycle re-arms the
  // pending flag after it is cleared, holding it for the next boundary.
  // Out-of-range indices match no cell and are silently dropped.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      back_q  <= '0;
      front_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      if (swap) begin
        front_q <= back_q;
        pend_q  <= 1'b0;
      end
      if (wr.commit) pend_q <= 1'b1;
      if (wr.clear_req) begin
        back_q <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < ROWS*COLUMNS; i++) begin
          if (int'(wr.wr_row) == i / COLUMNS && int'(wr.wr_col) == i % COLUMNS)
            back_q[i] <= wr.wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
module tb_led_matrix_scan_ctrl;
  localparam int ROWS    = 8;
  localparam int COLUMNS = 8;
  localparam int DWELL   = 4;
  localparam int BLANK   = 2;
  localparam int PER     = BLANK + DWELL;
  localparam int FRAME   = ROWS * PER;

  logic               clk_in = 1'b0;
  logic               rst_n  = 1'b0;
  logic               scan_en = 1'b0;
  logic [ROWS-1:0]    row_out;
  logic [COLUMNS-1:0] col_out;
  logic               frame_start;

  led_matrix_scan_ctrl_if #(.ROWS(ROWS), .COLUMNS(COLUMNS)) wif ();

  led_matrix_scan_ctrl #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .DWELL(DWELL), .BLANK(BLANK)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .wr          (wif),
    .row_out     (row_out),
    .col_out     (col_out),
    .frame_start (frame_start)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       fs;
    logic       pend;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: position within the frame, front/back images, pending.
  logic [COLUMNS-1:0] m_front [ROWS];
  logic [COLUMNS-1:0] m_back  [ROWS];
  bit                 m_run;
  bit                 m_pend;
  int                 m_pos;

  function automatic void m_clear();
    for (int r = 0; r < ROWS; r++) begin
      m_front[r] = '0;
      m_back[r]  = '0;
    end
    m_run  = 0;
    m_pend = 0;
    m_pos  = 0;
  endfunction

  function automatic obs_t m_out();
    obs_t o;
    int   r, ph;
    o = '0;
    if (m_run) begin
      r  = m_pos / PER;
      ph = m_pos % PER;
      o.fs = (m_pos == 0);
      if (ph >= BLANK) begin
        o.row[r] = 1'b1;
        o.col    = m_front[r];
      end
    end
    o.pend = m_pend;
    return o;
  endfunction

  initial begin
    m_clear();
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) begin
        m_clear();
      end else begin
        if (m_run && scan_en && m_pos == FRAME-1 && m_pend) begin
          for (int r = 0; r < ROWS; r++) m_front[r] = m_back[r];
          m_pend = 0;
        end
        if (wif.commit) m_pend = 1;
        if (wif.clear_req) begin
          for (int r = 0; r < ROWS; r++) m_back[r] = '0;
        end else if (wif.wr_valid) begin
          m_back[wif.wr_row][wif.wr_col] = wif.wr_data;
        end
        if (!scan_en) begin
          m_run = 0;
          m_pos = 0;
        end else if (!m_run) begin
          m_run = 1;
          m_pos = 0;
        end else begin
          m_pos = (m_pos + 1) % FRAME;
        end
        exp_q.push_back(m_out());
      end
    end
  end

  function automatic obs_t get_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.row  = row_out;
    o.col  = col_out;
    o.fs   = frame_start;
    o.pend = wif.commit_pending;
    return o;
  endfunction

  task automatic idle_inputs();
    wif.wr_valid  = 1'b0;
    wif.clear_req = 1'b0;
    wif.commit    = 1'b0;
  endtask

  task automatic drive_write(input int r, input int c, input logic d);
    wif.wr_valid = 1'b1;
    wif.wr_row   = 3'(r);
    wif.wr_col   = 3'(c);
    wif.wr_data  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    scan_en = 1'b0;
    idle_inputs();
    drive_write(0, 0, 1'b0);
    wif.wr_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    n_cmp++; if (row_out !== 8'h00) begin n_bad++; $display("FAIL reset_row_out got=%h want=00", row_out); end
    n_cmp++; if (col_out !== 8'h00) begin n_bad++; $display("FAIL reset_col_out got=%h want=00", col_out); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
    n_cmp++; if (wif.commit_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got=%b want=0", wif.commit_pending); end
    n_cmp++; if (wif.wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got=%b want=1", wif.wr_ready); end
    wif.clear_req = 1'b1;
    #1;
    n_cmp++; if (wif.wr_ready !== 1'b0) begin n_bad++; $display("FAIL ready_vs_clear got=%b want=0", wif.wr_ready); end
    wif.clear_req = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_scan_basic();
    obs_t e, o;
    int   fs_k[$];
    exp_q.delete();
    scan_en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_in);
      e = get_exp(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL scan_basic k=%0d got=%h want=%h", k, o, e); end
      if (frame_start === 1'b1) fs_k.push_back(k);
      if (k == 2) begin n_cmp++; if (row_out !== 8'h00) begin n_bad++; $display("FAIL scan_blank0 got=%h want=00", row_out); end end
      if (k == 3) begin n_cmp++; if (row_out !== 8'h01) begin n_bad++; $display("FAIL scan_row0 got=%h want=01", row_out); end end
      if (k == 9) begin n_cmp++; if (row_out !== 8'h02) begin n_bad++; $display("FAIL scan_row1 got=%h want=02", row_out); end end
    end
    n_cmp++;
    if (fs_k.size() < 2 || fs_k[0] != 1 || fs_k[1] != 1 + FRAME) begin
      n_bad++;
      $display("FAIL frame_period pulses=%0d first=%0d second=%0d want 1 and %0d",
               fs_k.size(), (fs_k.size() > 0) ? fs_k[0] : -1, (fs_k.size() > 1) ? fs_k[1] : -1, 1 + FRAME);
    end
  endtask

  task automatic test_write_commit();
    obs_t e, o;
    int   saw_pre, saw_post;
    saw_pre = 0; saw_post = 0;
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk_in);
      e = get_exp(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL write_commit k=%0d got=%h want=%h", k, o, e); end
      if (row_out === 8'h04 && col_out === 8'h20) begin
        if (k <= 61) saw_pre++; else saw_post++;
      end
      if (k == 61) begin n_cmp++; if (wif.commit_pending !== 1'b1) begin n_bad++; $display("FAIL commit_pending_set got=%b want=1", wif.commit_pending); end end
      idle_inputs();
      if (k == 1) drive_write(2, 5, 1'b1);
      if (k == 60) wif.commit = 1'b1;
    end
    n_cmp++; if (saw_pre != 0) begin n_bad++; $display("FAIL uncommitted_visible got=%0d want=0", saw_pre); end
    n_cmp++; if (saw_post < DWELL) begin n_bad++; $display("FAIL committed_pixel cycles=%0d want>=%0d", saw_post, DWELL); end
    n_cmp++; if (wif.commit_pending !== 1'b0) begin n_bad++; $display("FAIL commit_pending_clear got=%b want=0", wif.commit_pending); end
  endtask

  task automatic test_clear_vs_write();
    obs_t e, o;
    bit   pend_seen, after_swap;
    int   nz;
    pend_seen = 0; after_swap = 0; nz = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk_in);
      e = get_exp(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL clear_vs_write k=%0d got=%h want=%h", k, o, e); end
      if (wif.commit_pending === 1'b1) pend_seen = 1;
      else if (pend_seen) after_swap = 1;
      if (after_swap && col_out !== 8'h00) nz++;
      idle_inputs();
      if (k == 1) begin
        wif.clear_req = 1'b1;
        drive_write(3, 3, 1'b1);
        #1;
        n_cmp++; if (wif.wr_ready !== 1'b0) begin n_bad++; $display("FAIL clear_blocks_ready got=%b want=0", wif.wr_ready); end
      end
      if (k == 3) wif.commit = 1'b1;
    end
    n_cmp++; if (!after_swap || nz != 0) begin n_bad++; $display("FAIL cleared_frame swapped=%0d lit_cycles=%0d want 1 and 0", after_swap, nz); end
  endtask

  task automatic test_boundary_write();
    obs_t e, o;
    int   ph, kb, seen_mid, seen_post;
    ph = 0; kb = 0; seen_mid = 0; seen_post = 0;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk_in);
      e = get_exp(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL boundary_write k=%0d got=%h want=%h", k, o, e); end
      if (ph == 2 && row_out === 8'h10 && col_out[1] === 1'b1) seen_mid++;
      if (ph == 3 && row_out === 8'h10 && col_out[1] === 1'b1) seen_post++;
      idle_inputs();
      if (ph == 0 && m_run && m_pos == 10) begin
        wif.commit = 1'b1;
        ph = 1;
      end else if (ph == 1 && m_run && m_pos == FRAME-1) begin
        n_cmp++; if (wif.commit_pending !== 1'b1) begin n_bad++; $display("FAIL boundary_pending got=%b want=1", wif.commit_pending); end
        drive_write(4, 1, 1'b1);
        kb = k;
        ph = 2;
      end else if (ph == 2 && k == kb + FRAME + 2) begin
        wif.commit = 1'b1;
        ph = 3;
      end
    end
    n_cmp++; if (seen_mid != 0) begin n_bad++; $display("FAIL boundary_write_leaked cycles=%0d want=0", seen_mid); end
    n_cmp++; if (seen_post < DWELL) begin n_bad++; $display("FAIL boundary_write_late cycles=%0d want>=%0d", seen_post, DWELL); end
  endtask

  task automatic test_scan_en_drop();
    obs_t e, o;
    int   ph, kd, kr;
    ph = 0; kd = 0; kr = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk_in);
      e = get_exp(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL scan_en_drop k=%0d got=%h want=%h", k, o, e); end
      if (ph == 1 && k == kd + 1) begin
        n_cmp++; if (row_out !== 8'h00 || col_out !== 8'h00) begin n_bad++; $display("FAIL disable_blank row=%h col=%h want 00/00", row_out, col_out); end
      end
      if (ph == 2 && k == kr + 1) begin
        n_cmp++; if (frame_start !== 1'b1 || row_out !== 8'h00) begin n_bad++; $display("FAIL reenable_fs fs=%b row=%h want 1/00", frame_start, row_out); end
      end
      if (ph == 2 && k == kr + 3) begin
        n_cmp++; if (row_out !== 8'h01) begin n_bad++; $display("FAIL reenable_row0 got=%h want=01", row_out); end
      end
      if (ph == 0 && m_run && m_pos / PER == 5 && m_pos % PER >= BLANK) begin
        scan_en = 1'b0;
        kd = k;
        ph = 1;
      end else if (ph == 1 && k == kd + 3) begin
        scan_en = 1'b1;
        kr = k;
        ph = 2;
      end
    end
    n_cmp++; if (ph != 2) begin n_bad++; $display("FAIL scan_en_sequence phase=%0d want=2", ph); end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    bit   found, armed;
    int   nz;
    found = 0; armed = 0; nz = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk_in);
      e = get_exp(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_mid_pre k=%0d got=%h want=%h", k, o, e); end
      idle_inputs();
      if (armed) begin
        found = 1;
        break;
      end
      if (m_run && m_pos == 2*PER + BLANK) begin
        wif.commit = 1'b1;
        drive_write(6, 6, 1'b1);
        armed = 1;
      end
    end
    n_cmp++; if (!found || row_out !== 8'h04 || wif.commit_pending !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid_setup found=%0d row=%h pend=%b want 1/04/1", found, row_out, wif.commit_pending);
    end
    #2; rst_n = 1'b0;
    #1;
    n_cmp++; if (row_out !== 8'h00) begin n_bad++; $display("FAIL async_rst_row got=%h want=00", row_out); end
    n_cmp++; if (col_out !== 8'h00) begin n_bad++; $display("FAIL async_rst_col got=%h want=00", col_out); end
    n_cmp++; if (wif.commit_pending !== 1'b0) begin n_bad++; $display("FAIL async_rst_pend got=%b want=0", wif.commit_pending); end
    @(negedge clk_in);
    rst_n = 1'b1;
    exp_q.delete();
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk_in);
      e = get_exp(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_mid_post k=%0d got=%h want=%h", k, o, e); end
      if (k == 1) begin n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL restart_fs got=%b want=1", frame_start); end end
      if (col_out !== 8'h00) nz++;
      idle_inputs();
      if (k == 5) wif.commit = 1'b1;
    end
    n_cmp++; if (nz != 0) begin n_bad++; $display("FAIL buffers_after_reset lit_cycles=%0d want=0", nz); end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_write_commit();
    test_clear_vs_write();
    test_boundary_write();
    test_scan_en_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_matrix_scan_ctrl.md
# led_matrix_scan_ctrl

Row-multiplexing scan controller for the 8x8 LED matrix. Holds a double-buffered frame (back buffer written by game logic through a valid/ready port, front buffer displayed) and sequences row drive with a programmable dwell time and an all-off blanking gap between rows to suppress ghosting. It sits between the cursor/game logic and the matrix row/column drivers. It replaces ad-hoc per-LED serial scanning with a frame-coherent, tear-free update.

## Interface
Parameters:
- ROWS, 8, number of matrix rows
- COLUMNS, 8, number of matrix columns
- DWELL, 1000, clk_in cycles a row is driven (>=1)
- BLANK, 16, clk_in cycles all outputs off before each row (>=1)

Ports (one clock; reset is asynchronous and active-low):
- clk_in  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- scan_en  input  1  enables scanning; low forces blank output
- wr_valid  input  1  pixel write request
- wr_ready  output  1  write accepted when wr_valid & wr_ready
- wr_row  input  clog2(ROWS)  target row
- wr_col  input  clog2(COLUMNS)  target column
- wr_data  input  1  pixel value
- clear_req  input  1  one-cycle pulse: clear entire back buffer
- commit  input  1  one-cycle pulse: request back->front copy at next frame boundary
- commit_pending  output  1  commit requested, not yet applied
- row_out  output  ROWS  one-hot active-high row drive
- col_out  output  COLUMNS  active-high column data for driven row
- frame_start  output  1  one-cycle pulse when row 0 begins a new frame

## Operation
- FSM states: BLANK, DRIVE. Reset -> BLANK, row_idx=0, counter=0.
- BLANK: row_out=0, col_out=0; after BLANK cycles -> DRIVE.
- DRIVE: row_out=one-hot(row_idx), col_out=front[row_idx]; after DWELL cycles -> BLANK, row_idx increments.
- Wrap ROWS-1 -> 0 is the frame boundary: if commit_pending, front <= back and commit_pending clears in the same cycle; frame_start pulses for one cycle on the first BLANK cycle of row 0.
- Write: on wr_valid & wr_ready, back[wr_row][wr_col] <= wr_data. Out-of-range row/col (non-power-of-2 params) is accepted and dropped.
- wr_ready = ~clear_req (combinational). Clear wins over a simultaneous write; the write is not accepted.
- clear_req zeroes the back buffer only; front is unaffected until commit.
- Commit sets commit_pending. A second commit while pending has no additional effect. A commit in the boundary cycle is held for the next boundary.
- Swap samples back as registered before that cycle's write. A write in the boundary cycle lands in back only.
- scan_en low: next cycle state=BLANK, row_idx=0, counter=0, outputs 0, no frame_start. Writes, clear and commit still operate. A pending commit is applied on the first boundary after re-enable. Rising scan_en starts a full BLANK then row 0, with frame_start on the first BLANK cycle.
- rst_n low mid-frame: all state cleared immediately; both buffers zero.

## Timing
- Reset values: row_out=0, col_out=0, frame_start=0, commit_pending=0, buffers=0. wr_ready=1 while clear_req=0.
- All outputs except wr_ready are registered.
- Frame period = ROWS*(BLANK+DWELL) cycles. Row drive is exactly DWELL consecutive cycles. No cycle has two rows active.
- Write-to-back latency 1 cycle. Commit-to-display latency runs up to one frame period plus 1 cycle.
- Counter width clog2(max(DWELL,BLANK)+1), terminal compare at N-1.

## Structure
- Shared package led_matrix_pkg: ROWS/COLUMNS defaults, row/col index widths, scan state encoding (BLANK, DRIVE).
- One sub-module, scan_timer: loadable down-counter with terminal-count flag, reused for DWELL and BLANK.
- Buffers are flat ROWS*COLUMNS-bit registers, indexed row*COLUMNS+col.

## Test plan
Bench parameters: DWELL=4, BLANK=2, ROWS=COLUMNS=8.
- Reset then scan_en=1 -> frame_start at cycle 1. row_out=8'h01 during cycles 3-6, 8'h02 during cycles 9-12. col_out=0 throughout. Frame period is 48 cycles.
- Write (row 2, col 5, 1), no commit -> col_out stays 0 for row 2. Then commit -> commit_pending=1 until the next boundary. The following frame shows col_out=8'h20 while row_out=8'h04.
- clear_req and wr_valid in the same cycle -> wr_ready=0, write dropped. After commit, every row shows col_out=0.
- Write in the boundary cycle with commit pending -> that pixel is absent in the new frame and appears only after a further commit.
- scan_en dropped during row 5 DRIVE -> outputs 0 the next cycle. Re-enable -> 2 BLANK cycles, then row_out=8'h01, with frame_start.
- rst_n asserted mid-DRIVE -> row_out, col_out and commit_pending are 0 immediately (asynchronously). After release, front and back read all-zero.
